// File: rtl/alu_xb_pkg.sv
// Shared types and constants for the chunked incrementer/decrementer.
package alu_xb_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefChunk = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Chunk index width, never below one bit so a single-chunk build still has a register.
  function automatic int unsigned idx_width(input int unsigned width, input int unsigned chunk);
    int unsigned n;
    n = (chunk == 0) ? 1 : width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefIdxWidth = idx_width(DefWidth, DefChunk);

endpackage

// File: rtl/inc_chunk.sv
// Combinational CHUNK-bit add or subtract of a single carry/borrow bit.
module inc_chunk
  import alu_xb_pkg::*;
#(
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             carry_in,
  input  logic             dec,
  output logic [CHUNK-1:0] result,
  output logic             carry_out
);

  logic [CHUNK:0] sum;

  // The extra top bit is the carry-out on add and the borrow-out on subtract.
  always_comb begin
    if (dec) begin
      sum = {1'b0, chunk} - {{CHUNK{1'b0}}, carry_in};
    end else begin
      sum = {1'b0, chunk} + {{CHUNK{1'b0}}, carry_in};
    end
  end

  assign result    = sum[CHUNK-1:0];
  assign carry_out = sum[CHUNK];

endmodule

// File: rtl/incrementer_xb.sv
// Serial +/-1 unit processing CHUNK bits per clock with a valid/ready handshake on each side.
// Define INCREMENTER_XB_EARLY_DONE_EN to finish as soon as the carry/borrow dies out.
module incrementer_xb
  import alu_xb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int unsigned NumChunks = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IdxW      = idx_width(WIDTH, CHUNK);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gen_param_check
    $error("incrementer_xb: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              dec_q, dec_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [CHUNK-1:0]  chunk_cur;
  logic [CHUNK-1:0]  chunk_res;
  logic              chunk_carry;

  assign chunk_cur = data_q[idx_q*CHUNK +: CHUNK];

  inc_chunk #(
    .CHUNK (CHUNK)
  ) u_inc_chunk (
    .chunk     (chunk_cur),
    .carry_in  (carry_q),
    .dec       (dec_q),
    .result    (chunk_res),
    .carry_out (chunk_carry)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dec_d   = dec_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          dec_d   = in_dec;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        data_d[idx_q*CHUNK +: CHUNK] = chunk_res;
        carry_d = chunk_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
`ifdef INCREMENTER_XB_EARLY_DONE_EN
        // With no carry left the upper chunks are already final.
        if (!chunk_carry) begin
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      dec_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = data_q;
  assign out_carry = out_valid & carry_q;

endmodule

// File: tb/tb_incrementer_xb.sv
// Directed bench for incrementer_xb: vector table, backpressure, mid-operation reset and a
// small parameter sweep over three instances sharing clock and reset.
module tb_incrementer_xb;

`ifdef INCREMENTER_XB_EARLY_DONE_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: 16/4, b: 8/8, c: 32/2.
  logic        a_in_valid = 1'b0, a_in_ready, a_in_dec = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic        a_out_carry;
  logic [15:0] a_in_data = '0, a_out_data;
  logic        b_in_valid = 1'b0, b_in_ready, b_in_dec = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic        b_out_carry;
  logic [7:0]  b_in_data = '0, b_out_data;
  logic        c_in_valid = 1'b0, c_in_ready, c_in_dec = 1'b0, c_out_valid, c_out_ready = 1'b0;
  logic        c_out_carry;
  logic [31:0] c_in_data = '0, c_out_data;

  incrementer_xb #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk (clk), .rst (rst),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data), .in_dec (a_in_dec),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
    .out_carry (a_out_carry)
  );

  incrementer_xb #(.WIDTH(8), .CHUNK(8)) u_dut_w8 (
    .clk (clk), .rst (rst),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data), .in_dec (b_in_dec),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
    .out_carry (b_out_carry)
  );

  incrementer_xb #(.WIDTH(32), .CHUNK(2)) u_dut_w32 (
    .clk (clk), .rst (rst),
    .in_valid (c_in_valid), .in_ready (c_in_ready), .in_data (c_in_data), .in_dec (c_in_dec),
    .out_valid (c_out_valid), .out_ready (c_out_ready), .out_data (c_out_data),
    .out_carry (c_out_carry)
  );

  typedef struct {
    logic [15:0] din;
    logic        dec;
    logic [15:0] dout;
    logic        carry;
    int          lat_plain;
    int          lat_early;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_data(input int sel);
    case (sel)
      0:       return {16'h0, a_out_data};
      1:       return {24'h0, b_out_data};
      default: return c_out_data;
    endcase
  endfunction

  function automatic logic rd_valid(input int sel);
    case (sel)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic rd_ready(input int sel);
    case (sel)
      0:       return a_in_ready;
      1:       return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic logic rd_carry(input int sel);
    case (sel)
      0:       return a_out_carry;
      1:       return b_out_carry;
      default: return c_out_carry;
    endcase
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [31:0] d, input logic dec);
    case (sel)
      0: begin a_in_valid = v; a_in_data = d[15:0]; a_in_dec = dec; end
      1: begin b_in_valid = v; b_in_data = d[7:0];  b_in_dec = dec; end
      default: begin c_in_valid = v; c_in_data = d; c_in_dec = dec; end
    endcase
  endtask

  task automatic drive_ordy(input int sel, input logic r);
    case (sel)
      0:       a_out_ready = r;
      1:       b_out_ready = r;
      default: c_out_ready = r;
    endcase
  endtask

  // Edges from accept to out_valid when the first chunk that absorbs the carry ends the run.
  function automatic int model_lat(input logic [31:0] d, input logic dec, input int w, input int c);
    int n;
    logic [31:0] mask;
    logic [31:0] ch;
    n = w / c;
    if (!Early) return n;
    mask = (32'd1 << c) - 32'd1;
    for (int i = 0; i < n; i++) begin
      ch = (d >> (i * c)) & mask;
      if (dec ? (ch != 32'd0) : (ch != mask)) return i + 1;
    end
    return n;
  endfunction

  task automatic start_op(input int sel, input logic [31:0] d, input logic dec, input string name);
    drive_in(sel, 1'b1, d, dec);
    chk({name, " in_ready"}, 32'(rd_ready(sel)), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs while busy; they must not leak into the result.
    drive_in(sel, 1'b0, ~d, ~dec);
  endtask

  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!rd_valid(sel) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input int sel, input string name);
    drive_ordy(sel, 1'b1);
    #1;
    chk({name, " in_ready_in_done"}, 32'(rd_ready(sel)), 32'd0);
    @(posedge clk);
    #1;
    drive_ordy(sel, 1'b0);
    chk({name, " valid_after_hs"}, 32'(rd_valid(sel)), 32'd0);
    chk({name, " ready_after_hs"}, 32'(rd_ready(sel)), 32'd1);
  endtask

  task automatic run_op(input int sel, input logic [31:0] d, input logic dec,
                        input logic [31:0] exp_d, input logic exp_c, input int exp_lat,
                        input string name);
    int lat;
    start_op(sel, d, dec, name);
    wait_done(sel, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " data"}, rd_data(sel), exp_d);
    chk({name, " carry"}, 32'(rd_carry(sel)), 32'(exp_c));
    finish_op(sel, name);
  endtask

  task automatic sweep_one(input int sel, input int w, input int c, input logic [31:0] d_raw,
                           input logic dec, input string name);
    logic [31:0] mask;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_c;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    d     = d_raw & mask;
    exp_d = (dec ? d - 32'd1 : d + 32'd1) & mask;
    exp_c = dec ? (d == 32'd0) : (d == mask);
    run_op(sel, d, dec, exp_d, exp_c, model_lat(d, dec, w, c), name);
  endtask

  initial begin
    int lat;

    vecs[0] = '{16'h00FF, 1'b0, 16'h0100, 1'b0, 4, 3};
    vecs[1] = '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 4, 4};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFFF, 1'b1, 4, 4};
    vecs[3] = '{16'h1000, 1'b1, 16'h0FFF, 1'b0, 4, 4};
    vecs[4] = '{16'h1234, 1'b0, 16'h1235, 1'b0, 4, 1};
    vecs[5] = '{16'h1234, 1'b1, 16'h1233, 1'b0, 4, 1};
    vecs[6] = '{16'h7FFF, 1'b0, 16'h8000, 1'b0, 4, 4};
    vecs[7] = '{16'h8000, 1'b1, 16'h7FFF, 1'b0, 4, 4};
    vecs[8] = '{16'h0010, 1'b1, 16'h000F, 1'b0, 4, 2};
    vecs[9] = '{16'hFFFE, 1'b0, 16'hFFFF, 1'b0, 4, 1};

    // Reset state before any clock edge.
    #2;
    chk("rst in_ready", 32'(a_in_ready), 32'd1);
    chk("rst out_valid", 32'(a_out_valid), 32'd0);
    chk("rst out_data", {16'h0, a_out_data}, 32'd0);
    chk("rst out_carry", 32'(a_out_carry), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(0, {16'h0, vecs[i].din}, vecs[i].dec, {16'h0, vecs[i].dout}, vecs[i].carry,
             Early ? vecs[i].lat_early : vecs[i].lat_plain, $sformatf("vec%0d", i));
    end

    // Backpressure with a stray operand offered while the result is held.
    start_op(0, 32'h00FF, 1'b0, "bp");
    wait_done(0, lat);
    chk("bp latency", 32'(lat), Early ? 32'd3 : 32'd4);
    for (int i = 0; i < 5; i++) begin
      drive_in(0, i == 2, (i == 2) ? 32'hAAAA : 32'h5555, 1'b1);
      #1;
      chk($sformatf("bp data%0d", i), {16'h0, a_out_data}, 32'h0100);
      chk($sformatf("bp in_ready%0d", i), 32'(a_in_ready), 32'd0);
      chk($sformatf("bp valid%0d", i), 32'(a_out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    drive_in(0, 1'b0, 32'h0, 1'b0);
    chk("bp carry", 32'(a_out_carry), 32'd0);
    finish_op(0, "bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp no_extra_op", 32'(a_out_valid), 32'd0);

    // Reset after two chunks of a long operation.
    start_op(0, 32'hFFFF, 1'b0, "mid_rst");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst in_ready", 32'(a_in_ready), 32'd1);
    chk("mid_rst out_data", {16'h0, a_out_data}, 32'd0);
    chk("mid_rst out_carry", 32'(a_out_carry), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst idle", 32'(a_out_valid), 32'd0);
    run_op(0, 32'h1234, 1'b0, 32'h1235, 1'b0, Early ? 1 : 4, "post_rst");

    // Parameter sweep on the other two geometries, boundaries first.
    sweep_one(1, 8, 8, 32'hFF, 1'b0, "w8 ones_inc");
    sweep_one(1, 8, 8, 32'h00, 1'b1, "w8 zero_dec");
    sweep_one(2, 32, 2, 32'hFFFF_FFFF, 1'b0, "w32 ones_inc");
    sweep_one(2, 32, 2, 32'h0, 1'b1, "w32 zero_dec");
    sweep_one(2, 32, 2, 32'h0000_0100, 1'b1, "w32 borrow_run");
    for (int i = 0; i < 6; i++) begin
      sweep_one(1, 8, 8, $urandom, 1'($urandom_range(1, 0)), $sformatf("w8 rnd%0d", i));
      sweep_one(2, 32, 2, $urandom, 1'($urandom_range(1, 0)), $sformatf("w32 rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/incrementer_xb.md
INCREMENTER_XB -- requirements
Module: incrementer_xb

Interface
- REQ-001: Parameters SHALL be `WIDTH` (default 16) for the operand width in bits, and `CHUNK` (default 4) for the bits processed per clock. `WIDTH` SHALL be a multiple of `CHUNK`.
- REQ-002: Ports SHALL be as follows (clock and reset first).
  - clk  input  1  -- sole clock; all state updates on rising edge.
  - rst  input  1  -- reset; asynchronous, active-high.
  - in_valid  input  1  -- operand offered.
  - in_ready  output  1  -- block can accept an operand.
  - in_data  input  WIDTH  -- operand.
  - in_dec  input  1  -- operation select: 1 = decrement, 0 = increment.
  - out_valid  output  1  -- result available.
  - out_ready  input  1  -- consumer accepts the result.
  - out_data  output  WIDTH  -- result.
  - out_carry  output  1  -- carry-out on increment, or borrow-out on decrement.

Function
- REQ-003: The FSM SHALL have three states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- REQ-004: When in IDLE with in_valid=1, the block SHALL capture in_data and in_dec into internal registers on the clock edge, set the internal carry to 1 and the chunk index to 0, and move to BUSY.
- REQ-005: Each BUSY cycle SHALL update the chunk at the current index, where chunk index i covers bits [i*CHUNK +: CHUNK]:
  - increment: chunk + carry;
  - decrement: chunk - carry.
  The carry register SHALL take the chunk's carry-out (increment) or borrow-out (decrement), and the index SHALL increment.
- REQ-006: When the last chunk (index WIDTH/CHUNK-1) is processed, the FSM SHALL go to DONE. out_carry SHALL equal the final carry or borrow.
- REQ-007: Latency SHALL be as follows, with N = WIDTH/CHUNK:
  - Without the early-done feature, out_valid rises exactly N edges after the accepting edge.
  - With it, see REQ-013.
- REQ-008: Arithmetic SHALL be modulo 2^WIDTH (wrap-around). Boundary cases:
  - increment of all-ones gives 0 with out_carry=1;
  - decrement of 0 gives all-ones with out_carry=1;
  - in every other case out_carry=0.
- REQ-009: In DONE, out_data and out_carry SHALL hold stable until out_ready=1. The handshake edge SHALL return the FSM to IDLE.
- REQ-010: in_ready SHALL be 0 in the DONE cycle even if out_ready=1, so there is no same-cycle turnaround. The earliest new accept is the cycle after the output handshake.
- REQ-011: in_valid and in_data SHALL be ignored outside IDLE. Input changes during BUSY or DONE SHALL not affect the result.

Reset
- REQ-012: While rst=1, regardless of clk:
  - the FSM SHALL go to IDLE;
  - in_ready=1, out_valid=0, out_data=0, out_carry=0;
  - the internal index, carry and operand registers SHALL clear.
  Assertion mid-BUSY or mid-DONE SHALL abort the operation with no output handshake.

Configuration
- REQ-013: Macro `INCREMENTER_XB_EARLY_DONE_EN` SHALL control early termination.
  - Defined: when the carry register becomes 0 after a chunk, the FSM SHALL go to DONE on that edge. The remaining chunks SHALL pass through unchanged and out_carry=0. Latency is k+1 edges, where k is the index of the first chunk producing carry 0.
  - Undefined: all N chunks SHALL always be processed.
  - Results SHALL be identical in both builds; only latency differs.

Structure
- REQ-014: A shared package `alu_xb_pkg` SHALL hold:
  - the FSM state enum (IDLE/BUSY/DONE);
  - default WIDTH/CHUNK constants;
  - a helper constant for the index width, $clog2(WIDTH/CHUNK) with minimum 1.
- REQ-015: A combinational sub-module `inc_chunk` SHALL be used.
  - Parameter: CHUNK.
  - Inputs: chunk, carry_in, dec.
  - Outputs: chunk result, carry_out.
  - It SHALL be instantiated once and muxed by the index.
- REQ-016: An elaboration-time check SHALL fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Verification (WIDTH=16, CHUNK=4 unless stated)
- REQ-017: Increment 0x00FF, in_dec=0 -> out_data=0x0100, out_carry=0. out_valid SHALL appear 4 edges after accept without the macro and 3 edges with it.
- REQ-018: Increment 0xFFFF -> 0x0000, out_carry=1, 4 edges in both builds. Decrement 0x0000 -> 0xFFFF, out_carry=1.
- REQ-019: Decrement 0x1000 -> 0x0FFF, out_carry=0. With the macro, latency SHALL be 4 edges (borrow clears at chunk 3). Increment 0x1234 -> 0x1235 in 1 edge with the macro.
- REQ-020: Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout. Pulse in_valid with new data during DONE -> the data is ignored.
- REQ-021: Assert rst for 1 cycle mid-BUSY (after 2 chunks) -> same edge: out_valid=0, in_ready=1, out_data=0. A following operand completes correctly.
- REQ-022: Parameter sweep WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=2 with random operands -> results match (in±1) mod 2^WIDTH. Latency SHALL be WIDTH/CHUNK edges without the macro.
